// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: state codes, opcodes
// and the opcode class decoders used by the FSM and the store-strobe generator.
package mips_ctrl_pkg;

   localparam int unsigned OP_W    = 6;
   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_RST = 3'd0,
      ST_IF  = 3'd1,
      ST_IW  = 3'd2,
      ST_ID  = 3'd3,
      ST_EX  = 3'd4,
      ST_MEM = 3'd5,
      ST_MW  = 3'd6,
      ST_WB  = 3'd7
   } state_e;

   localparam logic [OP_W-1:0] OP_RTYPE  = 6'h00;
   localparam logic [OP_W-1:0] OP_REGIMM = 6'h01;
   localparam logic [OP_W-1:0] OP_J      = 6'h02;
   localparam logic [OP_W-1:0] OP_JAL    = 6'h03;
   localparam logic [OP_W-1:0] OP_BEQ    = 6'h04;
   localparam logic [OP_W-1:0] OP_BNE    = 6'h05;
   localparam logic [OP_W-1:0] OP_BLEZ   = 6'h06;
   localparam logic [OP_W-1:0] OP_BGTZ   = 6'h07;
   localparam logic [OP_W-1:0] OP_ADDIU  = 6'h09;
   localparam logic [OP_W-1:0] OP_SLTI   = 6'h0a;
   localparam logic [OP_W-1:0] OP_SLTIU  = 6'h0b;
   localparam logic [OP_W-1:0] OP_ANDI   = 6'h0c;
   localparam logic [OP_W-1:0] OP_ORI    = 6'h0d;
   localparam logic [OP_W-1:0] OP_XORI   = 6'h0e;
   localparam logic [OP_W-1:0] OP_LUI    = 6'h0f;
   localparam logic [OP_W-1:0] OP_LB     = 6'h20;
   localparam logic [OP_W-1:0] OP_LH     = 6'h21;
   localparam logic [OP_W-1:0] OP_LWL    = 6'h22;
   localparam logic [OP_W-1:0] OP_LW     = 6'h23;
   localparam logic [OP_W-1:0] OP_LBU    = 6'h24;
   localparam logic [OP_W-1:0] OP_LHU    = 6'h25;
   localparam logic [OP_W-1:0] OP_LWR    = 6'h26;
   localparam logic [OP_W-1:0] OP_SB     = 6'h28;
   localparam logic [OP_W-1:0] OP_SH     = 6'h29;
   localparam logic [OP_W-1:0] OP_SWL    = 6'h2a;
   localparam logic [OP_W-1:0] OP_SW     = 6'h2b;
   localparam logic [OP_W-1:0] OP_SWR    = 6'h2e;

   function automatic logic is_branch(input logic [OP_W-1:0] op);
      return op inside {OP_REGIMM, OP_J, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ};
   endfunction

   function automatic logic is_jal(input logic [OP_W-1:0] op);
      return op == OP_JAL;
   endfunction

   function automatic logic is_load(input logic [OP_W-1:0] op);
      return op inside {OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR};
   endfunction

   function automatic logic is_store(input logic [OP_W-1:0] op);
      return op inside {OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR};
   endfunction

   function automatic logic is_alu(input logic [OP_W-1:0] op);
      return op inside {OP_RTYPE, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI,
                        OP_XORI, OP_LUI};
   endfunction

endpackage

// File: rtl/store_strb_gen.sv
// Byte-lane write strobes for MIPS stores; word_base selects the 32-bit word
// inside a wider data bus, the low two address bits select lanes within it.
module store_strb_gen
   import mips_ctrl_pkg::*;
#(
   parameter  int unsigned DATA_W = 32,
   localparam int unsigned LANES  = DATA_W / 8,
   localparam int unsigned OFS_W  = $clog2(LANES)
) (
   input  logic             en,
   input  logic [OP_W-1:0]  op,
   input  logic [OFS_W-1:0] addr_lo,
   output logic [LANES-1:0] wen_c
);

   logic [1:0]       k4;
   logic [OFS_W-1:0] word_base;
   logic [OFS_W-1:0] half_base;
   logic [3:0]       swl_m;
   logic [3:0]       swr_m;

   always_comb begin
      k4        = addr_lo[1:0];
      word_base = addr_lo & ~OFS_W'(3);
      half_base = {addr_lo[OFS_W-1:1], 1'b0};
      swl_m     = 4'((5'd2 << k4) - 5'd1);
      swr_m     = 4'hF << k4;
      wen_c     = '0;
      if (en) begin
         case (op)
            OP_SW:   wen_c = LANES'(4'hF) << word_base;
            OP_SB:   wen_c = LANES'(1) << addr_lo;
            OP_SH:   wen_c = LANES'(2'b11) << half_base;
            OP_SWL:  wen_c = LANES'(swl_m) << word_base;
            OP_SWR:  wen_c = LANES'(swr_m) << word_base;
            default: wen_c = '0;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM with variable-latency instruction/data SRAM
// handshakes, byte-lane store strobes and cycle/retire performance counters.
module multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter  int unsigned DATA_W = 32,
   parameter  int unsigned CNT_W  = 32,
   localparam int unsigned LANES  = DATA_W / 8,
   localparam int unsigned OFS_W  = $clog2(LANES)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [OP_W-1:0]    behavior,
   input  logic               inst_ack,
   input  logic               data_ack,
   input  logic [OFS_W-1:0]   addr_lo,
   output logic               inst_req,
   output logic               ir_write,
   output logic               PC_enable,
   output logic               data_req,
   output logic               data_wr,
   output logic               reg_write,
   output logic               writing_back,
   output logic [LANES-1:0]   data_wen,
   output logic [STATE_W-1:0] state_o,
   output logic               illegal_op,
   output logic [CNT_W-1:0]   cycle_cnt,
   output logic [CNT_W-1:0]   retire_cnt
);

   state_e          state;
   state_e          state_nxt;
   logic [OP_W-1:0] op_q;
   logic [OP_W-1:0] op_nxt;
   logic            ill_set;
   logic            pc_raw;
   logic            ir_raw;
   logic            strb_en;

   // State, latched opcode, sticky illegal flag and performance counters
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_RST;
         op_q       <= '0;
         illegal_op <= 1'b0;
         cycle_cnt  <= '0;
         retire_cnt <= '0;
      end else begin
         state     <= state_nxt;
         op_q      <= op_nxt;
         cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (ill_set)
            illegal_op <= 1'b1;
         if (PC_enable)
            retire_cnt <= retire_cnt + CNT_W'(1);
      end
   end

   // Next-state and Moore decode; only ir_write/PC_enable see the acks
   always_comb begin
      state_nxt    = state;
      op_nxt       = op_q;
      ill_set      = 1'b0;
      pc_raw       = 1'b0;
      ir_raw       = 1'b0;
      strb_en      = 1'b0;
      inst_req     = 1'b0;
      data_req     = 1'b0;
      data_wr      = 1'b0;
      reg_write    = 1'b0;
      writing_back = 1'b0;
      case (state)
         ST_RST: state_nxt = ST_IF;
         ST_IF: begin
            inst_req  = 1'b1;
            state_nxt = ST_IW;
         end
         ST_IW: begin
            if (inst_ack) begin
               ir_raw    = 1'b1;
               op_nxt    = behavior;
               state_nxt = ST_ID;
            end
         end
         ST_ID: state_nxt = ST_EX;
         ST_EX: begin
            if (is_branch(op_q)) begin
               pc_raw    = 1'b1;
               state_nxt = ST_IF;
            end else if (is_jal(op_q) || is_alu(op_q)) begin
               state_nxt = ST_WB;
            end else if (is_load(op_q) || is_store(op_q)) begin
               state_nxt = ST_MEM;
            end else begin
               pc_raw    = 1'b1;
               ill_set   = 1'b1;
               state_nxt = ST_IF;
            end
         end
         ST_MEM: begin
            data_req  = 1'b1;
            data_wr   = is_store(op_q);
            strb_en   = 1'b1;
            state_nxt = ST_MW;
         end
         ST_MW: begin
            if (data_ack) begin
               if (is_store(op_q)) begin
                  pc_raw    = 1'b1;
                  state_nxt = ST_IF;
               end else begin
                  state_nxt = ST_WB;
               end
            end
         end
         ST_WB: begin
            reg_write    = 1'b1;
            writing_back = 1'b1;
            pc_raw       = 1'b1;
            state_nxt    = ST_IF;
         end
      endcase
      // A cycle that is being reset never commits an instruction fetch or retirement
      PC_enable = pc_raw & ~reset;
      ir_write  = ir_raw & ~reset;
   end

   assign state_o = STATE_W'(state);

   store_strb_gen #(.DATA_W(DATA_W)) u_strb (
      .en      (strb_en),
      .op      (op_q),
      .addr_lo (addr_lo),
      .wen_c   (data_wen)
   );

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, data bus width; legal values 32 and 64.
REQ-002 Parameter CNT_W, default 32, width of the performance counters.
REQ-003 Derived constant LANES = DATA_W/8; derived constant OFS_W = log2(LANES).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 behavior  in  6  opcode field of the instruction on the fetch bus; valid only in the inst_ack cycle.
REQ-007 inst_ack  in  1  instruction SRAM has returned data (variable latency, >=0 wait cycles).
REQ-008 data_ack  in  1  data SRAM has completed the access.
REQ-009 addr_lo  in  OFS_W  low bits of the ALU-computed effective address; valid in MEM.
REQ-010 inst_req, ir_write, PC_enable, data_req, data_wr, reg_write, writing_back  out  1 each  fetch request, IR load, PC update, data request, write qualifier, register-file write, WB indicator.
REQ-011 data_wen  out  LANES  byte-lane write strobes.
REQ-012 state_o  out  3  current state code; illegal_op  out  1  sticky unknown-opcode flag.
REQ-013 cycle_cnt, retire_cnt  out  CNT_W each  free-running cycle count and retired-instruction count.

Function
REQ-014 States and codes: RST=0, IF=1, IW=2, ID=3, EX=4, MEM=5, MW=6, WB=7; codes 0-7 are all reachable and there are no unused codes.
REQ-015 RST->IF unconditionally; IF->IW unconditionally; inst_req=1 only in IF.
REQ-016 IW holds until inst_ack; on inst_ack: ir_write=1 and behavior latched into op_q in the same cycle, next state ID.
REQ-017 ID->EX unconditionally.
REQ-018 EX branch/jump (beq, bne, j, regimm, blez, bgtz): PC_enable=1, next state IF.
REQ-019 EX jal: next state WB.
REQ-020 EX load/store (lw, lb, lbu, lh, lhu, lwl, lwr, sw, sb, sh, swl, swr): next state MEM.
REQ-021 EX other recognised opcodes (R-type, addiu, slti, sltiu, andi, ori, xori, lui): next state WB.
REQ-022 EX unrecognised opcode: PC_enable=1, illegal_op set, next state IF.
REQ-023 MEM lasts exactly one cycle: data_req=1, data_wr=1 for stores, data_wen driven; next state MW.
REQ-024 MW holds until data_ack, with data_req=0 while waiting; on data_ack a store gives PC_enable=1 and next state IF, and a load gives next state WB.
REQ-025 WB: reg_write=1, writing_back=1, PC_enable=1, next state IF; reg_write=0 in every other state.
REQ-026 Let k = addr_lo; data_wen is zero for every opcode except stores.
REQ-027 sw: low 4 lanes shifted to the 32-bit word select (addr_lo[OFS_W-1:2]<<2), or all 4 lanes when DATA_W=32.
REQ-028 sb: one lane, bit k.
REQ-029 sh: lanes k and k+1, with k[0] ignored.
REQ-030 swl: lanes word_base..word_base+(k mod 4).
REQ-031 swr: lanes word_base+(k mod 4)..word_base+3.
REQ-032 data_wen is nonzero only in the MEM cycle.
REQ-033 cycle_cnt increments every cycle not in reset and wraps to 0 after all-ones.
REQ-034 retire_cnt increments in every PC_enable cycle and wraps to 0 after all-ones.
REQ-035 An ack that arrives in a state not waiting for it (inst_ack outside IW, data_ack outside MW) is ignored.
REQ-036 All outputs are decoded from state and op_q only (Moore), apart from the ack-qualified pulses ir_write and PC_enable in IW and MW.

Reset
REQ-037 Reset asserted in any cycle, including while waiting in IW or MW, gives the next state RST and clears op_q, illegal_op, cycle_cnt and retire_cnt.
REQ-038 While in RST all 1-bit outputs are 0, data_wen=0 and state_o=0; a pending ack during reset is discarded.

Structure
REQ-039 The state codes, opcode constants and class-decode functions belong in the shared package mips_ctrl_pkg.
REQ-040 Strobe generation is the sub-module store_strb_gen, parametrised by DATA_W; the FSM and counters stay in multicycle_ctrl.

Verification
REQ-041 addiu with inst_ack after 0 wait cycles: state sequence 1,2,3,4,7,1; reg_write high for 1 cycle; retire_cnt=1 after 6 cycles from reset release.
REQ-042 DATA_W=32, sb, addr_lo=2'b10, data_ack after 3 waits: data_wen=4'b0100 only in MEM; PC_enable pulses in the data_ack cycle; no reg_write.
REQ-043 DATA_W=64, swr, addr_lo=3'b101: data_wen=8'b1110_0000; with swl at the same address, data_wen=8'b0011_0000.
REQ-044 beq: EX->IF with PC_enable=1; no MEM or WB visit. Opcode 6'b111111: illegal_op=1 and stays 1 until reset.
REQ-045 Reset asserted mid-MW with data_ack in the same cycle: next state 0, counters 0, no PC_enable pulse.
REQ-046 CNT_W=4: after 16 retirements retire_cnt wraps to 0.
